// File: rtl/morph_pkg.sv
// Shared types and sizing helpers for the binary morphology stages.
package morph_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int WIN = 3;

  // Beat counter must reach W*H+W (last flush beat) without wrapping.
  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + w + 2);
  endfunction

endpackage

// File: rtl/bin_line_buffer.sv
// One-bit delay line of DEPTH beats built on an inferred RAM with registered read.
// While a beat is being presented, bit_o holds the bit written DEPTH beats earlier.
module bin_line_buffer #(
  parameter int DEPTH = 640
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_en_i,
  input  logic bit_i,
  output logic bit_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr;
  logic          bit_reg;

  // Reading one slot ahead of the write pointer hides the RAM read latency.
  always_comb begin
    rd_ptr = wr_ptr_reg + 1'b1;
    if (wr_ptr_reg == AW'(DEPTH - 1)) begin
      rd_ptr = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      bit_reg    <= 1'b0;
    end else if (shift_en_i) begin
      wr_ptr_reg <= rd_ptr;
      bit_reg    <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (shift_en_i) begin
      mem[wr_ptr_reg] <= bit_i;
    end
  end

  assign bit_o = bit_reg;

endmodule

// File: rtl/binary_erode3x3.sv
// Streaming 3x3 binary erosion with forced-zero border and an internal flush tail.
// Optional MORPH_DILATE_SEL_EN adds dilate_sel_i to switch interior pixels to dilation.
module binary_erode3x3
  import morph_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pixel_datav_i,
  input  logic                  pixel_sof_i,
  input  logic [DATA_WIDTH-1:0] pixel_data_i,
`ifdef MORPH_DILATE_SEL_EN
  input  logic                  dilate_sel_i,
`endif
  output logic                  erode_datav_o,
  output logic                  erode_sof_o,
  output logic [DATA_WIDTH-1:0] erode_data_o,
  output logic                  overrun_o
);

  localparam int CW = cnt_width(IMG_WIDTH, IMG_HEIGHT);

  localparam logic [CW-1:0] LAST_PIX  = CW'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(IMG_WIDTH * IMG_HEIGHT + IMG_WIDTH);
  localparam logic [CW-1:0] FIRST_OUT = CW'(IMG_WIDTH + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(IMG_HEIGHT - 1);

  state_e                  state_reg;
  logic [CW-1:0]           beat_cnt_reg;
  logic [CW-1:0]           out_col_reg;
  logic [CW-1:0]           out_row_reg;
  logic                    datav_reg;
  logic                    sof_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    overrun_reg;

  logic                    beat;
  logic                    restart;
  logic                    px_in;
  logic [CW-1:0]           beat_idx;
  logic                    emit;
  logic                    interior;
  logic                    fg_all;
  logic                    hit;

  logic                    lb0_bit;
  logic                    lb1_bit;
  logic [WIN-1:0]          new_col;
  logic [WIN-1:0]          win_col_reg [WIN-1];
  logic [WIN*WIN-1:0]      window;

  // Beat qualification: accepted input in RUN/IDLE-start, forced zero pixel in FLUSH.
  always_comb begin
    beat    = 1'b0;
    restart = 1'b0;
    px_in   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pixel_datav_i && pixel_sof_i) begin
          beat    = 1'b1;
          restart = 1'b1;
          px_in   = |pixel_data_i;
        end
      end
      RUN: begin
        if (pixel_datav_i) begin
          beat    = 1'b1;
          restart = pixel_sof_i;
          px_in   = |pixel_data_i;
        end
      end
      FLUSH: begin
        beat = 1'b1;
      end
      default: begin
        beat = 1'b0;
      end
    endcase
    beat_idx = restart ? '0 : beat_cnt_reg;
    emit     = beat && (beat_idx >= FIRST_OUT);
  end

  bin_line_buffer #(
    .DEPTH(IMG_WIDTH)
  ) u_lb0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .shift_en_i(beat),
    .bit_i     (px_in),
    .bit_o     (lb0_bit)
  );

  bin_line_buffer #(
    .DEPTH(IMG_WIDTH)
  ) u_lb1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .shift_en_i(beat),
    .bit_i     (lb0_bit),
    .bit_o     (lb1_bit)
  );

  // Newest column is {row r-1, row r, row r+1}; older columns live in registers.
  assign new_col = {lb1_bit, lb0_bit, px_in};

  genvar gi;
  generate
    for (gi = 0; gi < WIN - 1; gi++) begin : g_win
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i) begin
          if (beat) begin
            win_col_reg[gi] <= new_col;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk_i) begin
          if (beat) begin
            win_col_reg[gi] <= win_col_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign window   = {new_col, win_col_reg[0], win_col_reg[1]};
  assign fg_all   = &window;
  assign interior = (out_row_reg != '0) && (out_row_reg != LAST_ROW) &&
                    (out_col_reg != '0) && (out_col_reg != LAST_COL);

`ifdef MORPH_DILATE_SEL_EN
  logic fg_any;
  assign fg_any = |window;
  assign hit    = dilate_sel_i ? fg_any : fg_all;
`else
  assign hit    = fg_all;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      out_col_reg  <= '0;
      out_row_reg  <= '0;
      datav_reg    <= 1'b0;
      sof_reg      <= 1'b0;
      data_reg     <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      datav_reg <= emit;
      sof_reg   <= emit && (out_col_reg == '0) && (out_row_reg == '0);
      data_reg  <= (emit && interior && hit) ? '1 : '0;

      if (state_reg == FLUSH && pixel_datav_i) begin
        overrun_reg <= 1'b1;
      end

      if (beat) begin
        beat_cnt_reg <= beat_idx + 1'b1;
      end

      if (restart) begin
        out_col_reg <= '0;
        out_row_reg <= '0;
      end else if (emit) begin
        if (out_col_reg == LAST_COL) begin
          out_col_reg <= '0;
          out_row_reg <= out_row_reg + 1'b1;
        end else begin
          out_col_reg <= out_col_reg + 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (restart) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (beat && beat_idx == LAST_PIX) begin
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (beat_idx == LAST_BEAT) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            out_col_reg  <= '0;
            out_row_reg  <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign erode_datav_o = datav_reg;
  assign erode_sof_o   = sof_reg;
  assign erode_data_o  = data_reg;
  assign overrun_o     = overrun_reg;

endmodule

// File: tb/tb_binary_erode3x3.sv
// Randomised bench for binary_erode3x3: 4x4 and 5x5 instances checked against a raster-level model.
module tb_binary_erode3x3;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       sof;
    int         cyc;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       v4, s4, v5, s5;
  logic [7:0] d4, d5;
  logic       ev4, es4, ov4, ev5, es5, ov5;
  logic [7:0] ed4, ed5;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   img [0:24];
  int   in_cyc [0:24];
  out_t q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_erode3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .pixel_datav_i(v4), .pixel_sof_i(s4), .pixel_data_i(d4),
`ifdef MORPH_DILATE_SEL_EN
    .dilate_sel_i(1'b0),
`endif
    .erode_datav_o(ev4), .erode_sof_o(es4), .erode_data_o(ed4), .overrun_o(ov4)
  );

  binary_erode3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .pixel_datav_i(v5), .pixel_sof_i(s5), .pixel_data_i(d5),
`ifdef MORPH_DILATE_SEL_EN
    .dilate_sel_i(1'b0),
`endif
    .erode_datav_o(ev5), .erode_sof_o(es5), .erode_data_o(ed5), .overrun_o(ov5)
  );

  always @(negedge clk) begin
    out_t e;
    if (ev4 === 1'b1) begin
      e.inst = 4; e.data = ed4; e.sof = es4; e.cyc = cyc;
      q.push_back(e);
    end
    if (ev5 === 1'b1) begin
      e.inst = 5; e.data = ed5; e.sof = es5; e.cyc = cyc;
      q.push_back(e);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Erosion from the definition: border forced 0, interior needs all 9 neighbours set.
  function automatic bit model_px(input int w, input int h, input int n);
    int r = n / w;
    int c = n % w;
    if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!img[(r + dr) * w + (c + dc)]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill(input int n, input int pct);
    for (int i = 0; i < 25; i++) img[i] = (i < n) && ($urandom_range(99) < pct);
  endtask

  task automatic drive(input int inst, input bit v, input bit s, input logic [7:0] d);
    @(negedge clk);
    v4 = (inst == 4) && v;  s4 = (inst == 4) && s;  d4 = (inst == 4) ? d : 8'h00;
    v5 = (inst == 5) && v;  s5 = (inst == 5) && s;  d5 = (inst == 5) ? d : 8'h00;
  endtask

  task automatic send_frame(input int inst, input int gap_pct, input int n_send, input bit junk,
                            output int t_start, output int c_last);
    int g;
    t_start = cyc;
    c_last  = cyc;
    if (junk) begin
      drive(inst, 1'b1, 1'b0, 8'hFF);
      drive(inst, 1'b0, 1'b0, 8'h00);
    end
    for (int i = 0; i < n_send; i++) begin
      g = 0;
      while (i > 0 && g < 6 && $urandom_range(99) < gap_pct) begin
        drive(inst, 1'b0, 1'b0, 8'h00);
        g++;
      end
      drive(inst, 1'b1, (i == 0), img[i] ? 8'($urandom_range(1, 255)) : 8'h00);
      in_cyc[i] = cyc;
      if (i == 0) t_start = cyc;
      c_last = cyc;
    end
  endtask

  task automatic finish_frame(input int inst, input bit poke);
    int w = (inst == 5) ? 5 : 4;
    for (int j = 1; j <= w + 4; j++) drive(inst, poke && (j == 2), 1'b0, 8'hA5);
  endtask

  // Output n is due the cycle after beat n+W+1; beats past the last pixel are flush cycles.
  task automatic check_frame(input int inst, input int t_start, input int c_last, input string name);
    int   w = (inst == 5) ? 5 : 4;
    int   n_px = w * w;
    int   got = 0;
    int   k;
    int   exp_cyc;
    out_t e;
    while (q.size() > 0 && q[0].cyc <= t_start) e = q.pop_front();
    while (q.size() > 0) begin
      e = q.pop_front();
      if (got < n_px) begin
        k = got + w + 1;
        exp_cyc = (k <= n_px - 1) ? in_cyc[k] + 1 : c_last + (k - (n_px - 1)) + 1;
        check_eq($sformatf("%s.inst[%0d]", name, got), e.inst, inst);
        check_eq($sformatf("%s.data[%0d]", name, got), e.data, model_px(w, w, got) ? 8'hFF : 8'h00);
        check_eq($sformatf("%s.sof[%0d]", name, got), e.sof, (got == 0));
        check_eq($sformatf("%s.cyc[%0d]", name, got), e.cyc, exp_cyc);
      end
      got++;
    end
    check_eq($sformatf("%s.count", name), got, n_px);
    $display("[TB] frame %s inst=%0d outputs=%0d", name, inst, got);
  endtask

  task automatic run_frame(input int inst, input int gap_pct, input bit junk, input bit poke,
                           input string name);
    int ts, cl;
    send_frame(inst, gap_pct, inst * inst, junk, ts, cl);
    finish_frame(inst, poke);
    check_frame(inst, ts, cl, name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, cl, t_rst, cnt;
    rst = 1'b1;
    v4 = 0; s4 = 0; d4 = 0; v5 = 0; s5 = 0; d5 = 0;
    repeat (3) drive(4, 1'b0, 1'b0, 8'h00);
    check_eq("rst.datav4", ev4, 0);
    check_eq("rst.sof4", es4, 0);
    check_eq("rst.data4", ed4, 0);
    check_eq("rst.ovr4", ov4, 0);
    check_eq("rst.datav5", ev5, 0);
    check_eq("rst.ovr5", ov5, 0);
    rst = 1'b0;
    drive(4, 1'b0, 1'b0, 8'h00);

    fill(16, 100);
    run_frame(4, 0, 1'b0, 1'b0, "ones");
    check_eq("ovr.after_ones", ov4, 0);

    fill(16, 100); img[6] = 1'b0;
    run_frame(4, 0, 1'b0, 1'b0, "hole6");

    fill(16, 100);
    run_frame(4, 50, 1'b1, 1'b0, "gaps");

    fill(16, 100);
    send_frame(4, 0, 7, 1'b0, ts, cl);
    fill(16, 85);
    send_frame(4, 0, 16, 1'b0, ts, cl);
    finish_frame(4, 1'b0);
    check_frame(4, ts, cl, "abort7");
    check_eq("ovr.after_abort", ov4, 0);

    fill(16, 100);
    run_frame(4, 0, 1'b0, 1'b1, "flush_poke");
    check_eq("ovr.set", ov4, 1);

    for (int i = 0; i < 4; i++) begin
      fill(16, 85);
      run_frame(4, 30, 1'b0, 1'b0, $sformatf("rand4_%0d", i));
    end
    check_eq("ovr.sticky", ov4, 1);

    fill(16, 100);
    send_frame(4, 0, 10, 1'b0, ts, cl);
    @(negedge clk);
    rst = 1'b1; v4 = 0; s4 = 0; d4 = 0;
    t_rst = cyc;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst.datav", ev4, 0);
    check_eq("midrst.sof", es4, 0);
    check_eq("midrst.data", ed4, 0);
    check_eq("midrst.ovr", ov4, 0);
    repeat (12) drive(4, 1'b0, 1'b0, 8'h00);
    cnt = 0;
    foreach (q[i]) if (q[i].cyc > t_rst) cnt++;
    check_eq("midrst.late_outputs", cnt, 0);
    $display("[TB] frame midrst inst=4 late_outputs=%0d", cnt);
    q.delete();

    fill(16, 100);
    run_frame(4, 0, 1'b0, 1'b0, "after_rst");

    fill(25, 100); img[0] = 1'b0;
    run_frame(5, 0, 1'b0, 1'b0, "5x5_hole0");
    for (int i = 0; i < 3; i++) begin
      fill(25, 85);
      run_frame(5, 40, 1'b1, 1'b0, $sformatf("rand5_%0d", i));
    end
    check_eq("ovr5.clear", ov5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
